// File: rtl/ysyx_220053_ifu_pkg.sv
// Shared IFU definitions: FSM state encoding, reset PC and the canonical NOP.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_220053_ifu_pkg;

  // Fetch FSM states; the numeric encoding is relied on by debug tooling.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_e;

  // Architectural PC after reset.
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  // addi x0, x0, 0 -- presented in the instruction register after reset.
  localparam logic [31:0] IFU_NOP = 32'h0000_0013;

  // No compressed-instruction support: any PC with bit 1 set cannot be fetched.
  // Bit 0 is already cleared by execute, so only bit 1 matters here.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo[1];
  endfunction

endpackage

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over req/gnt/rvalid.
// Latency: inst_valid two cycles after imem_req at best (gnt, then rvalid next cycle); 1 instr / 3 cycles.
// Backpressure: request held until gnt; fetched instruction held until commit; no new fetch meanwhile.
module ysyx_220053_ifu
  import ysyx_220053_ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = IFU_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic [XLEN-1:0] dnpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault,
  output logic [63:0]     retired
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [63:0]     retired_q, retired_d;

  // Next-state logic: FETCH waits for gnt, WAIT for the response, HOLD for commit.
  // rvalid is only looked at in WAIT, so a response coinciding with gnt is ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (imem_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (commit) begin
          // The commit retires even when the next PC turns out to be unfetchable.
          retired_d = retired_q + 64'd1;
          pc_d      = dnpc;
          state_d   = pc_misaligned(dnpc[1:0]) ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers; reset abandons any outstanding request and restarts at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= IFU_NOP;
      retired_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  // Control outputs are forced low during reset so nothing downstream acts on stale state.
  assign imem_req    = ~rst & (state_q == ST_FETCH);
  assign inst_valid  = ~rst & (state_q == ST_HOLD);
  assign fetch_fault = ~rst & (state_q == ST_FAULT);

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
module tb_ysyx_220053_ifu;

  localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          NCYC     = 6000;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [63:0] dnpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        fetch_fault;
  logic [63:0] retired;

  ysyx_220053_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .dnpc        (dnpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc          (pc),
    .fetch_fault (fetch_fault),
    .retired     (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected observable events: an instruction presented, or the fault indicator rising.
  typedef struct {
    bit          is_fault;
    int unsigned cyc;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] retired;
  } ev_t;

  ev_t         ev_q[$];
  logic [63:0] addr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0] ^ a[47:32], a[31:16] ^ a[63:48]} ^ 32'h0050_0093;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          prev_iv, prev_ff, prev_commit, rst_prev;
  logic [63:0] cur_pc;
  logic [31:0] cur_inst;

  task automatic take_event(input bit is_fault);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event at cycle %0d: got kind %0d expected none", cyc, is_fault);
      return;
    end
    e = ev_q.pop_front();
    chk("event_kind", 64'(is_fault), 64'(e.is_fault));
    chk("event_cycle", 64'(cyc), 64'(e.cyc));
    chk("event_pc", pc, e.pc);
    chk("event_retired", retired, e.retired);
    if (!is_fault) chk("event_inst", 64'(inst), 64'(e.inst));
    cur_pc   = e.pc;
    cur_inst = e.inst;
  endtask

  initial begin
    prev_iv = 0; prev_ff = 0; prev_commit = 0; rst_prev = 0;
    cur_pc = '0; cur_inst = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("outputs_low_in_reset", {61'd0, imem_req, inst_valid, fetch_fault}, 64'd0);
        rst_prev = 1; prev_iv = 0; prev_ff = 0; prev_commit = 0;
      end else begin
        if (rst_prev) begin
          chk("reset_pc", pc, RST_PC);
          chk("reset_inst", 64'(inst), 64'(NOP_WORD));
          chk("reset_retired", retired, 64'd0);
          chk("reset_req", 64'(imem_req), 64'd1);
        end
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL overdue_event at cycle %0d: got nothing expected kind %0d by cycle %0d",
                   cyc, ev_q[0].is_fault, ev_q[0].cyc);
          void'(ev_q.pop_front());
        end
        if (imem_gnt) chk("req_at_gnt", 64'(imem_req), 64'd1);
        if (imem_req) begin
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req at cycle %0d: got addr %h expected no request", cyc, imem_addr);
          end else begin
            chk("imem_addr", imem_addr, addr_q[0]);
            if (imem_gnt) void'(addr_q.pop_front());
          end
        end
        if (inst_valid && !prev_iv) take_event(1'b0);
        if (fetch_fault && !prev_ff) take_event(1'b1);
        if (inst_valid && prev_iv) begin
          chk("hold_pc_stable", pc, cur_pc);
          chk("hold_inst_stable", 64'(inst), 64'(cur_inst));
        end
        if (prev_iv) chk("hold_until_commit", 64'(inst_valid), 64'(!prev_commit));
        if (fetch_fault) begin
          chk("fault_quiet", {62'd0, inst_valid, imem_req}, 64'd0);
          chk("fault_pc_stable", pc, cur_pc);
        end
        if (prev_ff) chk("fault_sticky", 64'(fetch_fault), 64'd1);
        prev_iv = inst_valid; prev_ff = fetch_fault; prev_commit = commit; rst_prev = 0;
      end
    end
  end

  // ---------------- stimulus + reference model + memory ----------------
  logic [63:0] m_pc, m_retired;
  bit          req_pending, resp_owed, presented, faulted;
  int          gnt_dly, rv_dly, hold_dly, fault_left, rst_left;

  function automatic logic [63:0] pick_dnpc(input logic [63:0] cur);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    if (r == 1) return {$urandom, $urandom} & ~64'h1 | 64'h2;
    if (r == 2) return {$urandom, $urandom} & ~64'h3;
    return cur + 64'(4 * $urandom_range(1, 8));
  endfunction

  initial begin
    ev_t e;
    rst = 1; commit = 0; dnpc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; imem_err = 0;
    m_pc = RST_PC; m_retired = 0;
    req_pending = 0; resp_owed = 0; presented = 0; faulted = 0;
    gnt_dly = 0; rv_dly = 0; hold_dly = 0; fault_left = 0; rst_left = 2;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      commit = 0; imem_gnt = 0; imem_rvalid = 0; imem_err = 0;
      imem_rdata = $urandom;
      dnpc = {$urandom, $urandom} & ~64'h1;
      if (rst_left == 0 && !rst &&
          (faulted ? (fault_left == 0) : ($urandom_range(0, 99) == 0))) begin
        rst_left = $urandom_range(1, 2);
        ev_q.delete();
        addr_q.delete();
      end
      if (rst_left > 0) begin
        // Reset must win over any concurrent handshake or commit.
        rst = 1;
        rst_left--;
        commit = $urandom_range(0, 1);
        imem_gnt = $urandom_range(0, 1);
        imem_rvalid = $urandom_range(0, 1);
      end else begin
        if (rst) begin
          rst = 0;
          m_pc = RST_PC; m_retired = 0;
          resp_owed = 0; presented = 0; faulted = 0;
          req_pending = 1;
          gnt_dly = $urandom_range(0, 5);
          addr_q.push_back(m_pc);
        end
        if (faulted) begin
          if (fault_left > 0) fault_left--;
          commit = $urandom_range(0, 1);
          imem_rvalid = $urandom_range(0, 1);
          imem_err = $urandom_range(0, 1);
        end else if (req_pending) begin
          commit = ($urandom_range(0, 3) == 0);
          imem_rvalid = ($urandom_range(0, 3) == 0);
          imem_err = $urandom_range(0, 1);
          if (gnt_dly == 0) begin
            imem_gnt = 1;
            req_pending = 0;
            resp_owed = 1;
            rv_dly = $urandom_range(0, 3);
          end else begin
            gnt_dly--;
          end
        end else if (resp_owed) begin
          commit = ($urandom_range(0, 3) == 0);
          if (rv_dly == 0) begin
            imem_rvalid = 1;
            resp_owed = 0;
            if ($urandom_range(0, 15) == 0) begin
              imem_err = 1;
              faulted = 1;
              fault_left = $urandom_range(3, 8);
              e = '{is_fault: 1'b1, cyc: cyc + 1, pc: m_pc, inst: 32'd0, retired: m_retired};
              ev_q.push_back(e);
            end else begin
              imem_rdata = mem_word(m_pc);
              presented = 1;
              hold_dly = $urandom_range(0, 4);
              e = '{is_fault: 1'b0, cyc: cyc + 1, pc: m_pc, inst: mem_word(m_pc), retired: m_retired};
              ev_q.push_back(e);
            end
          end else begin
            rv_dly--;
          end
        end else if (presented) begin
          if (hold_dly == 0) begin
            commit = 1;
            dnpc = pick_dnpc(m_pc);
            presented = 0;
            m_retired = m_retired + 64'd1;
            m_pc = dnpc;
            if (dnpc[1]) begin
              faulted = 1;
              fault_left = $urandom_range(3, 8);
              e = '{is_fault: 1'b1, cyc: cyc + 1, pc: m_pc, inst: 32'd0, retired: m_retired};
              ev_q.push_back(e);
            end else begin
              req_pending = 1;
              gnt_dly = $urandom_range(0, 5);
              addr_q.push_back(m_pc);
            end
          end else begin
            hold_dly--;
          end
        end
      end
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_ifu.md
Name: ysyx_220053_ifu

Overview:
Instruction fetch unit; sits directly upstream of the decode/execute path.
- Owns the architectural PC register.
- Issues one instruction-memory request per instruction over a req/gnt/rvalid handshake.
- Presents the fetched 32-bit instruction and its PC, held stable until the execute stage signals commit.
- On commit, loads the next-PC produced by execute and starts the next fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- XLEN, 64, PC and address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- commit  in  1  execute has finished the presented instruction; dnpc is valid this cycle.
- dnpc  in  XLEN  next PC from execute; bit 0 is already cleared.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data or error returned this cycle.
- imem_rdata  in  32  instruction word.
- imem_err  in  1  access fault; qualified by imem_rvalid.
- inst_valid  out  1  inst and pc are valid for decode/execute.
- inst  out  32  fetched instruction.
- pc  out  XLEN  PC of inst / current fetch address.
- fetch_fault  out  1  sticky fault indicator.
- retired  out  64  count of accepted commits.

Behaviour:
Reset (rst=1 at an edge):
- pc=RESET_PC, state=FETCH, inst=32'h0000_0013 (NOP), retired=0.
- All 1-bit outputs are 0 while rst is high.
- An outstanding request is abandoned. The memory model must be reset together with this block, so no stale rvalid arrives afterwards.

States (registered):
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until gnt.
  - imem_gnt=1 -> WAIT.
  - imem_rvalid in FETCH is ignored.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 & imem_err=0 -> inst<=imem_rdata, go to HOLD.
  - imem_rvalid=1 & imem_err=1 -> FAULT.
  - Otherwise stay.
- HOLD:
  - inst_valid=1; inst and pc are stable.
  - commit=1 -> retired<=retired+1, pc<=dnpc.
    - If dnpc[1]=1 (misaligned; no compressed support) -> FAULT.
    - Otherwise -> FETCH.
  - commit=0 -> stay.
- FAULT:
  - fetch_fault=1, inst_valid=0, imem_req=0.
  - Stays here until rst.

Rules:
- commit outside HOLD is ignored: no pc change, no count.
- Minimum latency: gnt in the first FETCH cycle and rvalid in the first WAIT cycle give inst_valid two cycles after the request is raised. Back-to-back throughput is one instruction per 3 cycles (FETCH, WAIT, HOLD).
- gnt and rvalid in the same cycle: only gnt is honoured (FETCH). rvalid must arrive at least one cycle after gnt.
- pc arithmetic is modulo 2^XLEN; dnpc=64'hFFFF_FFFF_FFFF_FFFC is legal.
- retired wraps from 2^64-1 to 0.
- rst has priority over commit, gnt and rvalid in the same cycle.

Decomposition:
Shared package:
- State encoding: FETCH=2'd0, WAIT=2'd1, HOLD=2'd2, FAULT=2'd3.
- RESET_PC default.
- NOP encoding 32'h0000_0013.

No sub-module. The FSM, PC register, instruction register and retire counter are small enough to sit inline.

Test Plan:
1. Reset release, memory gnt same cycle, rvalid next cycle, rdata=32'h00500093 -> imem_addr=0x80000000 at cycle 0; inst_valid=1, inst=32'h00500093, pc=0x80000000 at cycle 2.
2. In HOLD, commit=1 with dnpc=0x80000010 -> next cycle imem_req=1, imem_addr=0x80000010, retired=1; commit pulsed during WAIT -> no change.
3. gnt withheld 5 cycles, then rvalid delayed 3 cycles -> imem_addr stable at pc throughout; inst_valid asserts exactly one cycle after rvalid.
4. rvalid=1 with imem_err=1 -> fetch_fault=1 and inst_valid=0 indefinitely; commit ignored; rst -> pc=0x80000000, fetch_fault=0.
5. commit with dnpc=0x80000006 -> FAULT, fetch_fault=1, no request issued; retired still increments by 1.
6. rst asserted mid-WAIT -> next cycle state FETCH, pc=RESET_PC, inst=NOP, retired=0; after rst release, imem_req=1.
